// File: rtl/regfile_ctrl_seq.sv
// Three-cycle instruction sequencer for the 4x8 register file (A-D).
// Drives registered read/write selects and ALU controls per 16-bit instr.
module regfile_ctrl_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic             c4,
  output logic             c5,
  output logic             c6,
  output logic             c7,
  output logic             c8,
  output logic             c9,
  output logic             c10,
  output logic [1:0]       alu_op,
  output logic             imm_sel,
  output logic [7:0]       imm,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0] op;
  logic       accept;
  logic       dec_wr;
  logic       dec_ill;
  logic       dec_isel;
  logic [1:0] dec_op;
  logic [1:0] rx_q;
  logic       wr_q;
  logic       ill_q;

  assign op          = instr[15:12];
  assign instr_ready = (state == IDLE);
  assign accept      = instr_valid & instr_ready;

  always_comb begin
    dec_wr   = 1'b0;
    dec_ill  = 1'b0;
    dec_isel = 1'b0;
    dec_op   = 2'b00;
    unique case (1'b1)
      (op == 4'h0): ;
      (op == 4'h4): dec_wr = 1'b1;
      (op == 4'h5): begin
        dec_wr   = 1'b1;
        dec_op   = 2'b11;
        dec_isel = 1'b1;
      end
      (op == 4'h6): begin
        dec_wr = 1'b1;
        dec_op = 2'b01;
      end
      (op == 4'h7): begin
        dec_wr   = 1'b1;
        dec_op   = 2'b01;
        dec_isel = 1'b1;
      end
      (op == 4'h8): begin
        dec_wr = 1'b1;
        dec_op = 2'b10;
      end
      (op == 4'h9): begin
        dec_wr   = 1'b1;
        dec_op   = 2'b10;
        dec_isel = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Selects and ALU controls load on accept so they are stable all of READ.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {c4, c5}  <= 2'b00;
      {c6, c7}  <= 2'b00;
      {c8, c9}  <= 2'b00;
      c10       <= 1'b0;
      alu_op    <= 2'b00;
      imm_sel   <= 1'b0;
      imm       <= 8'h00;
      done      <= 1'b0;
      illegal   <= 1'b0;
      retired   <= '0;
      rx_q      <= 2'b00;
      wr_q      <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          {c4, c5} <= instr[11:10];
          {c6, c7} <= instr[9:8];
          imm      <= instr[7:0];
          rx_q     <= instr[11:10];
          wr_q     <= dec_wr;
          ill_q    <= dec_ill;
          alu_op   <= dec_op;
          imm_sel  <= dec_isel;
        end
        READ: begin
          {c8, c9} <= rx_q;
          c10      <= wr_q;
          done     <= 1'b1;
          illegal  <= ill_q;
          retired  <= retired + CNT_W'(1);
        end
        EXEC: begin
          c10     <= 1'b0;
          done    <= 1'b0;
          illegal <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_ctrl_seq.sv
// Randomized bench for regfile_ctrl_seq with a register file + ALU model
// and an instruction-level golden register image.
module tb_regfile_ctrl_seq;

  localparam int CW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic [15:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          c4, c5, c6, c7, c8, c9, c10;
  logic [1:0]    alu_op;
  logic          imm_sel;
  logic [7:0]    imm;
  logic          done;
  logic          illegal;
  logic [CW-1:0] retired;

  int nchk  = 0;
  int nfail = 0;

  logic [7:0]    rf [4];
  logic [7:0]    g  [4];
  logic [7:0]    rd1, rd2, opb, res;
  logic          init_en = 1'b1;
  logic [CW-1:0] cnt = '0;

  always #5 clock = ~clock;

  regfile_ctrl_seq #(.CNT_W(CW)) dut (
    .clock(clock),
    .reset(reset),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .c4(c4), .c5(c5), .c6(c6), .c7(c7),
    .c8(c8), .c9(c9), .c10(c10),
    .alu_op(alu_op),
    .imm_sel(imm_sel),
    .imm(imm),
    .done(done),
    .illegal(illegal),
    .retired(retired)
  );

  // Register file with registered read ports, plus the datapath ALU.
  always_comb begin
    opb = imm_sel ? imm : rd2;
    res = rd2;
    case (alu_op)
      2'b01:   res = rd1 + opb;
      2'b10:   res = rd1 - opb;
      2'b11:   res = imm;
      default: res = rd2;
    endcase
  end

  always @(posedge clock) begin
    if (init_en) begin
      for (int i = 0; i < 4; i++) rf[i] <= g[i];
    end else begin
      rd1 <= rf[{c4, c5}];
      rd2 <= rf[{c6, c7}];
      if (c10) rf[{c8, c9}] <= res;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {write, alu_op, imm_sel, illegal} from the opcode table
  function automatic logic [4:0] expect_ctl(input logic [3:0] o);
    case (o)
      4'h0:    return 5'b0_00_0_0;
      4'h4:    return 5'b1_00_0_0;
      4'h5:    return 5'b1_11_1_0;
      4'h6:    return 5'b1_01_0_0;
      4'h7:    return 5'b1_01_1_0;
      4'h8:    return 5'b1_10_0_0;
      4'h9:    return 5'b1_10_1_0;
      default: return 5'b0_00_0_1;
    endcase
  endfunction

  task automatic golden(input logic [15:0] ins);
    int x, y;
    logic [7:0] k;
    x = int'(ins[11:10]);
    y = int'(ins[9:8]);
    k = ins[7:0];
    case (ins[15:12])
      4'h4:    g[x] = g[y];
      4'h5:    g[x] = k;
      4'h6:    g[x] = g[x] + g[y];
      4'h7:    g[x] = g[x] + k;
      4'h8:    g[x] = g[x] - g[y];
      4'h9:    g[x] = g[x] - k;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] gimg();
    return {g[3], g[2], g[1], g[0]};
  endfunction

  function automatic logic [31:0] rimg();
    return {rf[3], rf[2], rf[1], rf[0]};
  endfunction

  // Entered and left at a falling edge while the sequencer is idle.
  task automatic run(input logic [15:0] ins);
    logic [4:0] e;
    e = expect_ctl(ins[15:12]);
    instr       = ins;
    instr_valid = 1'b1;
    chk("ready_idle", 32'(instr_ready), 32'd1);
    @(posedge clock);
    #1;
    instr       = 16'($urandom);
    instr_valid = 1'($urandom);
    cnt         = cnt + 1'b1;
    @(negedge clock);
    chk("ready_read", 32'(instr_ready), 32'd0);
    chk("rsel1_read", 32'({c4, c5}), 32'(ins[11:10]));
    chk("rsel2_read", 32'({c6, c7}), 32'(ins[9:8]));
    chk("c10_read", 32'({c10, done}), 32'd0);
    @(negedge clock);
    chk("ready_exec", 32'(instr_ready), 32'd0);
    chk("rsel_exec", 32'({c4, c5, c6, c7}), 32'(ins[11:8]));
    chk("c10_exec", 32'(c10), 32'(e[4]));
    if (e[4]) chk("wsel_exec", 32'({c8, c9}), 32'(ins[11:10]));
    chk("aluop_exec", 32'(alu_op), 32'(e[3:2]));
    chk("isel_exec", 32'(imm_sel), 32'(e[1]));
    chk("imm_exec", 32'(imm), 32'(ins[7:0]));
    chk("done_exec", 32'(done), 32'd1);
    chk("ill_exec", 32'(illegal), 32'(e[0]));
    chk("retired", 32'(retired), 32'(cnt));
    golden(ins);
    @(negedge clock);
    chk("pulse_idle", 32'({c10, done, illegal}), 32'd0);
    chk("rf_image", rimg(), gimg());
  endtask

  task automatic reset_in_exec(input logic [15:0] ins);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("c10_pre_rst", 32'(c10), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    cnt = '0;
    chk("c10_rst", 32'(c10), 32'd0);
    chk("done_rst", 32'(done), 32'd0);
    chk("retired_rst", 32'(retired), 32'd0);
    chk("ready_rst", 32'(instr_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_post", 32'(instr_ready), 32'd1);
    chk("rf_no_write", rimg(), gimg());
  endtask

  initial begin
    for (int i = 0; i < 4; i++) g[i] = 8'($urandom);
    reset       = 1'b1;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_clines", 32'({c4, c5, c6, c7, c8, c9, c10}), 32'd0);
    chk("rst_ctl", 32'({alu_op, imm_sel, imm, done, illegal}), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    init_en = 1'b0;
    reset   = 1'b0;
    @(negedge clock);

    run(16'h512A);
    run(16'h542A);
    run(16'h6900);
    run(16'h8800);
    run(16'hF000);
    run(16'h0000);
    reset_in_exec(16'h7C01);
    run(16'h4300);
    run(16'h6F00);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        instr_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      run(16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
